// File: rtl/rs_15_11_encoder.sv
// Systematic RS(15,11) encoder over GF(16) (x^4+x+1): 11 message symbols pass through,
// then 4 parity symbols from the generator LFSR, each tagged with its block index.
module rs_15_11_encoder #(
  parameter logic [3:0] G3 = 4'hD,
  parameter logic [3:0] G2 = 4'hC,
  parameter logic [3:0] G1 = 4'h8,
  parameter logic [3:0] G0 = 4'h7
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       IN_VALID,
  input  logic [3:0] DATA_IN,
  output logic       IN_READY,
  output logic       OUT_VALID,
  output logic [3:0] DATA_OUT,
  output logic [3:0] COUNT,
  output logic       SOB,
  output logic       EOB
);

  // state   | meaning
  // ST_MSG  | accepting message symbols, counter 0..10
  // ST_PAR  | shifting out parity, counter 11..14
  typedef enum logic [1:0] {
    ST_MSG = 2'd0,
    ST_PAR = 2'd1
  } state_t;

  state_t     state;
  logic [3:0] sym_cnt;
  logic [3:0] r3, r2, r1, r0;
  logic [3:0] fb;
  logic       bad_state;

  // Constant-coefficient GF(16) multiply; b is always a parameter so this folds to XORs.
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] p;
    acc = 4'h0;
    p   = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ p;
      p = {p[2:0], 1'b0} ^ {2'b00, p[3], p[3]};
    end
    return acc;
  endfunction

  assign fb = DATA_IN ^ r3;

  always_comb begin
    bad_state = 1'b1;
    if (state == ST_MSG && sym_cnt <= 4'd10)
      bad_state = 1'b0;
    else if (state == ST_PAR && sym_cnt >= 4'd11 && sym_cnt != 4'hF)
      bad_state = 1'b0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= ST_MSG;
      sym_cnt   <= 4'd0;
      r3        <= 4'h0;
      r2        <= 4'h0;
      r1        <= 4'h0;
      r0        <= 4'h0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      DATA_OUT  <= 4'h0;
      COUNT     <= 4'd0;
      SOB       <= 1'b0;
      EOB       <= 1'b0;
    end else if (bad_state) begin
      // Corrupted state/counter pair: drop the block and restart clean.
      state     <= ST_MSG;
      sym_cnt   <= 4'd0;
      r3        <= 4'h0;
      r2        <= 4'h0;
      r1        <= 4'h0;
      r0        <= 4'h0;
      IN_READY  <= 1'b1;
      OUT_VALID <= 1'b0;
      SOB       <= 1'b0;
      EOB       <= 1'b0;
    end else begin
      case (state)
        ST_MSG: begin
          if (IN_VALID) begin
            r3        <= r2 ^ gf_mul(fb, G3);
            r2        <= r1 ^ gf_mul(fb, G2);
            r1        <= r0 ^ gf_mul(fb, G1);
            r0        <= gf_mul(fb, G0);
            DATA_OUT  <= DATA_IN;
            COUNT     <= sym_cnt;
            OUT_VALID <= 1'b1;
            SOB       <= (sym_cnt == 4'd0);
            EOB       <= 1'b0;
            sym_cnt   <= sym_cnt + 4'd1;
            if (sym_cnt == 4'd10) begin
              state    <= ST_PAR;
              IN_READY <= 1'b0;
            end
          end else begin
            OUT_VALID <= 1'b0;
            SOB       <= 1'b0;
            EOB       <= 1'b0;
          end
        end
        ST_PAR: begin
          DATA_OUT  <= r3;
          COUNT     <= sym_cnt;
          OUT_VALID <= 1'b1;
          SOB       <= 1'b0;
          EOB       <= (sym_cnt == 4'd14);
          r3        <= r2;
          r2        <= r1;
          r1        <= r0;
          r0        <= 4'h0;
          if (sym_cnt == 4'd14) begin
            state    <= ST_MSG;
            sym_cnt  <= 4'd0;
            IN_READY <= 1'b1;
          end else begin
            sym_cnt <= sym_cnt + 4'd1;
          end
        end
        default: begin
          state   <= ST_MSG;
          sym_cnt <= 4'd0;
        end
      endcase
    end
  end

endmodule
